bin_to_bcd_serial: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the two-digit seven-segment display decoder. Its `bcd` output drives the decoder's 8-bit BCD input: low nibble is units, high nibble is tens. It uses a start/ready/valid handshake and saturates out-of-range values to all nines with an overflow flag.

---
 rtl/bin_to_bcd_serial_pkg.sv | 29 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin_to_bcd_serial.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_serial.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bin_to_bcd_serial_pkg;

  localparam int unsigned default_binwidth = 7;
  localparam int unsigned default_digits   = 2;
  localparam int unsigned max_digits       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must hold the value binwidth itself.
  function automatic int unsigned cnt_width(input int unsigned bw);
    return $clog2(bw + 1);
  endfunction

  // Saturation pattern: n digits of 4'h9, zero above.
  function automatic logic [4*max_digits-1:0] all_nines(input int unsigned n);
    logic [4*max_digits-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < max_digits; k++) begin
      if (k < n) r[4*k +: 4] = 4'h9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted_c
);

  always_comb begin
    adjusted_c = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// saturating to all nines with an overflow flag.
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int unsigned binwidth = default_binwidth,
  parameter int unsigned digits   = default_digits
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [binwidth-1:0]   bin,
  output logic                  ready,
  output logic                  valid,
  output logic [digits*4-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned bcdw = digits * 4;
  localparam int unsigned cntw = cnt_width(binwidth);
  localparam logic [bcdw-1:0] nines = bcdw'(all_nines(digits));

  state_t              state_q,   state_d;
  logic [binwidth-1:0] sr_q,      sr_d;
  logic [bcdw-1:0]     scratch_q, scratch_d;
  logic [cntw-1:0]     cnt_q,     cnt_d;
  logic                sticky_q,  sticky_d;
  logic [bcdw-1:0]     bcd_d;
  logic                ovf_d;
  logic                ready_d;
  logic                valid_d;
  logic [bcdw-1:0]     adj_c;

  for (genvar k = 0; k < digits; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit      (scratch_q[4*k +: 4]),
      .adjusted_c (adj_c[4*k +: 4])
    );
  end

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd;
    ovf_d     = overflow;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = bin;
          scratch_d = '0;
          cnt_d     = cntw'(binwidth);
          sticky_d  = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Bit leaving the top digit means the value exceeds the digit range.
        scratch_d = {adj_c[bcdw-2:0], sr_q[binwidth-1]};
        sr_d      = {sr_q[binwidth-2:0], 1'b0};
        sticky_d  = sticky_q | adj_c[bcdw-1];
        cnt_d     = cnt_q - cntw'(1);
        if (cnt_q == cntw'(1)) begin
          state_d = DONE;
          bcd_d   = sticky_d ? nines : scratch_d;
          ovf_d   = sticky_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      ready     <= 1'b1;
      valid     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      bcd       <= bcd_d;
      overflow  <= ovf_d;
      ready     <= ready_d;
      valid     <= valid_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial with a result scoreboard.
module tb_bin_to_bcd_serial;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic [6:0] bin   = '0;
  logic       ready;
  logic       valid;
  logic [7:0] bcd;
  logic       overflow;

  typedef struct packed {
    logic [7:0] bcd;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   valid_count = 0;

  bin_to_bcd_serial dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .bin      (bin),
    .ready    (ready),
    .valid    (valid),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int unsigned v);
    exp_t e;
    if (v > 99) begin
      e.bcd = 8'h99;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every result strobe consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && valid === 1'b1) begin
      valid_count++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid bcd=%h overflow=%b", bcd, overflow);
      end else begin
        e = q.pop_front();
        if (bcd !== e.bcd) begin
          errors++;
          $display("FAIL result_bcd got=%h expected=%h", bcd, e.bcd);
        end
        checks++;
        if (overflow !== e.ovf) begin
          errors++;
          $display("FAIL result_overflow got=%b expected=%b", overflow, e.ovf);
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic convert(input int unsigned v);
    int c0;
    bit seen;
    step;
    start = 1'b1;
    bin   = 7'(v);
    q.push_back(model(v));
    c0 = valid_count;
    step;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step;
      if (valid_count > c0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL convert_timeout bin=%0d valid_count=%0d expected>%0d", v, valid_count, c0);
      q.delete();
    end
    step;
  endtask

  task automatic test_reset;
    repeat (3) step;
    rstn = 1'b1;
    step;
    checks++;
    if ({ready, valid, bcd, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b bcd=%h ovf=%b expected 1 0 00 0",
               ready, valid, bcd, overflow);
    end
    for (int i = 0; i < 20; i++) begin
      step;
      checks++;
      if ({ready, valid, bcd, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cycle=%0d got ready=%b valid=%b bcd=%h ovf=%b expected 1 0 00 0",
                 i, ready, valid, bcd, overflow);
      end
    end
  endtask

  task automatic test_nominal;
    int c0;
    step;
    start = 1'b1;
    bin   = 7'd42;
    q.push_back(model(42));
    c0 = valid_count;
    for (int k = 0; k <= 8; k++) begin
      step;
      if (k == 0) start = 1'b0;
      checks++;
      if (ready !== (k == 8)) begin
        errors++;
        $display("FAIL nominal_ready after_edge=E%0d got=%b expected=%b", k, ready, (k == 8));
      end
      checks++;
      if (valid !== (k == 7)) begin
        errors++;
        $display("FAIL nominal_valid after_edge=E%0d got=%b expected=%b", k, valid, (k == 7));
      end
    end
    checks++;
    if (valid_count != c0 + 1) begin
      errors++;
      $display("FAIL nominal_valid_count got=%0d expected=%0d", valid_count - c0, 1);
    end
  endtask

  task automatic test_boundaries;
    int unsigned vals[4] = '{0, 9, 10, 99};
    foreach (vals[i]) convert(vals[i]);
  endtask

  task automatic test_overflow;
    int unsigned vals[3] = '{100, 127, 5};
    foreach (vals[i]) convert(vals[i]);
  endtask

  task automatic test_busy;
    int c0;
    step;
    start = 1'b1;
    bin   = 7'd37;
    q.push_back(model(37));
    c0 = valid_count;
    for (int k = 0; k <= 9; k++) begin
      step;
      case (k)
        0: begin start = 1'b0; bin = 7'd88; end
        2: start = 1'b1;
        3: start = 1'b0;
        7: start = 1'b1;
        8: start = 1'b0;
        default: ;
      endcase
      if (k >= 8) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL busy_no_requeue after_edge=E%0d ready got=%b expected=1", k, ready);
        end
      end
    end
    repeat (12) step;
    checks++;
    if (valid_count != c0 + 1) begin
      errors++;
      $display("FAIL busy_single_valid got=%0d expected=1", valid_count - c0);
    end
  endtask

  task automatic test_reset_midop;
    int c0;
    step;
    start = 1'b1;
    bin   = 7'd64;
    q.push_back(model(64));
    c0 = valid_count;
    step;
    start = 1'b0;
    repeat (4) step;
    rstn = 1'b0;
    #1;
    checks++;
    if ({ready, valid, bcd, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset got ready=%b valid=%b bcd=%h ovf=%b expected 1 0 00 0",
               ready, valid, bcd, overflow);
    end
    q.delete();
    repeat (2) step;
    rstn = 1'b1;
    repeat (12) step;
    checks++;
    if (valid_count != c0) begin
      errors++;
      $display("FAIL midop_no_valid got=%0d expected=0", valid_count - c0);
    end
    convert(64);
  endtask

  task automatic test_back_to_back;
    int c0;
    step;
    start = 1'b1;
    bin   = 7'd23;
    q.push_back(model(23));
    c0 = valid_count;
    for (int k = 0; k <= 26; k++) begin
      step;
      case (k)
        0, 9, 18: bin = 7'h55;
        8:  begin bin = 7'd81;  q.push_back(model(81));  end
        17: begin bin = 7'd120; q.push_back(model(120)); end
        26: start = 1'b0;
        default: ;
      endcase
      if (k == 8 || k == 9) begin
        checks++;
        if (ready !== (k == 8)) begin
          errors++;
          $display("FAIL b2b_ready after_edge=E%0d got=%b expected=%b", k, ready, (k == 8));
        end
      end
    end
    repeat (12) step;
    checks++;
    if (valid_count != c0 + 3 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d pending=%0d expected=3 pending=0",
               valid_count - c0, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_overflow();
    test_busy();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
